// File: rtl/hs_pkg.sv
// Shared definitions for the byte valid/ready channel: byte width, byte type,
// and the default stall watchdog limit.
package hs_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] hs_data_t;

  localparam int STALL_LIMIT_DEFAULT = 16;

endpackage

// File: rtl/hs_byte_fifo_src_if.sv
// Byte channel bundle: producer side (in_*) and responder side (valid/data/ready).
// The master modport is the FIFO source stage and the slave modport is its environment.
interface hs_byte_fifo_src_if;
  import hs_pkg::*;

  logic     in_valid;
  hs_data_t in_data;
  logic     in_ready;
  logic     valid;
  hs_data_t data;
  logic     ready;

  modport master (
    input  in_valid,
    input  in_data,
    input  ready,
    output in_ready,
    output valid,
    output data
  );

  modport slave (
    output in_valid,
    output in_data,
    output ready,
    input  in_ready,
    input  valid,
    input  data
  );

endinterface

// File: rtl/hs_stall_wdog.sv
// Stall watchdog: counts consecutive cycles where the head byte is offered but
// not taken, and raises a sticky error once the count reaches STALL_LIMIT.
module hs_stall_wdog #(
  parameter int STALL_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic ready,
  output logic stall_err
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          stalled;

  assign stalled   = valid && !ready;
  assign stall_err = stall_q;

  // Next count (saturating, cleared whenever the stall is broken) and sticky flag
  always_comb begin
    cnt_d   = '0;
    stall_d = stall_q;
    if (stalled) begin
      if (cnt_q != CW'(STALL_LIMIT)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (cnt_q == CW'(STALL_LIMIT - 1)) begin
        stall_d = 1'b1;
      end
    end
  end

  // Counter and flag registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: rtl/hs_byte_fifo_src.sv
// Byte FIFO source stage: buffers producer bytes and presents the head byte
// first-word fall-through on the valid/ready channel. A full FIFO refuses pushes
// even when a pop happens in the same cycle, giving a one-cycle bubble.
// Optional feature macro: HS_STALL_WDOG_EN enables the stall watchdog; when
// undefined stall_err is tied low and no watchdog logic exists.
module hs_byte_fifo_src
  import hs_pkg::*;
#(
  parameter int DEPTH = 8
`ifdef HS_STALL_WDOG_EN
  , parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  hs_byte_fifo_src_if.master         ch,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       stall_err
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  hs_data_t      mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);

  assign ch.in_ready = !rst && !full;
  assign ch.valid    = !empty;
  assign ch.data     = mem_q[rd_ptr_q];
  assign level       = level_q;

  assign push = ch.in_valid && ch.in_ready;
  assign pop  = ch.valid && ch.ready;

  // Pointer advance and occupancy update from this cycle's push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers; reset empties the FIFO so valid drops immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Byte storage; the head slot is never the write target unless the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ch.in_data;
    end
  end

`ifdef HS_STALL_WDOG_EN
  hs_stall_wdog #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .valid     (ch.valid),
    .ready     (ch.ready),
    .stall_err (stall_err)
  );
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_byte_fifo_src.sv
// Bench for hs_byte_fifo_src: directed stimulus drives a reference occupancy
// model and an expected-byte queue; a separate monitor checks presented bytes,
// ordering and the hold rules of the output channel.
module tb_hs_byte_fifo_src;

  localparam int DEPTH = 8;
  localparam int LIMIT = 16;

  logic       clk;
  logic       rst;
  logic [3:0] level;
  logic       stall_err;

  hs_byte_fifo_src_if ch ();

  hs_byte_fifo_src #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch        (ch.master),
    .level     (level),
    .stall_err (stall_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         m_lvl = 0;
  int         m_cnt = 0;
  logic       m_stall = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check state at negedge, advance model at posedge
  task automatic cycle(input logic iv, input logic [7:0] id, input logic rdy);
    logic do_push;
    logic do_pop;
    ch.in_valid = iv;
    ch.in_data  = id;
    ch.ready    = rdy;
    @(negedge clk);
    chk("level", int'(level), m_lvl);
    chk("in_ready", int'(ch.in_ready), int'(m_lvl != DEPTH));
    chk("valid", int'(ch.valid), int'(m_lvl != 0));
    chk("stall_err", int'(stall_err), int'(m_stall));
    @(posedge clk);
    do_push = iv && (m_lvl != DEPTH);
    do_pop  = rdy && (m_lvl != 0);
    if ((m_lvl != 0) && !rdy) m_cnt++;
    else m_cnt = 0;
`ifdef HS_STALL_WDOG_EN
    if (m_cnt >= LIMIT) m_stall = 1'b1;
`endif
    if (do_push) exp_q.push_back(id);
    m_lvl = m_lvl + int'(do_push) - int'(do_pop);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    ch.in_valid = 1'b0;
    ch.in_data  = 8'h00;
    ch.ready    = 1'b0;
    #1;
    chk("rst_valid_async", int'(ch.valid), 0);
    chk("rst_level_async", int'(level), 0);
    chk("rst_in_ready", int'(ch.in_ready), 0);
    chk("rst_stall_err", int'(stall_err), 0);
    m_lvl   = 0;
    m_cnt   = 0;
    m_stall = 1'b0;
    exp_q.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_in_ready_hold", int'(ch.in_ready), 0);
      chk("rst_valid_hold", int'(ch.valid), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: head byte order and hold-while-stalled protocol checks
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", int'(ch.valid), 1);
        chk("hold_data", int'(ch.data), int'(prev_data));
      end
      if (ch.valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL head: valid=1 data=0x%0h but no byte expected at %0t", ch.data, $time);
        end else begin
          chk("data", int'(ch.data), int'(exp_q[0]));
          if (ch.ready) void'(exp_q.pop_front());
        end
      end
      hold_prev = ch.valid && !ch.ready;
      prev_data = ch.data;
    end
  end

  initial begin
    rst         = 1'b0;
    ch.in_valid = 1'b0;
    ch.in_data  = 8'h00;
    ch.ready    = 1'b0;
    #2;

    // Reset for 3 cycles, then idle: ready to accept, empty
    do_reset(3);
    cycle(1'b0, 8'h00, 1'b0);

    // Single byte held while the responder stalls, then popped
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill to full, refused extra byte, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h08, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Full with push and pop in the same cycle: only the pop happens
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 8'h08, 1'b1);
    cycle(1'b1, 8'h08, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Streaming at occupancy 1, pointers wrap several times
    cycle(1'b1, 8'h20, 1'b0);
    for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Reset in mid-operation discards contents
    cycle(1'b1, 8'hC1, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    do_reset(2);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hD7, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Long stall: watchdog trips after LIMIT cycles and stays set until reset
    do_reset(1);
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (LIMIT) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    do_reset(2);
    cycle(1'b0, 8'h00, 1'b0);

    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
